board_move_register: RTL and testbench
======================================

Name: board_move_register

Overview:
- Upstream stage of the players-error checker. Accepts one move request at a time: player bit plus cell index 0..8.
- Rejects moves to illegal or occupied cells and commits legal moves into the board registers.
- Drives the occupancy vector, the last-mover bit and the toggling update strobe that the error checker consumes.
- Evaluates win/draw after each commit and freezes the board once the game ends.

Parameters:
- FIRST_PLAYER, 1'b0: value of the player output after reset or clear (0 = X, 1 = O).
- ENFORCE_TURN, 0: when 1, a move from the same player as the last accepted move is rejected (move_err). When 0, it is committed and the downstream checker flags it.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous new-game request, one-cycle pulse
- move_valid  in  1  move request present
- move_player  in  1  requesting player (0 = X, 1 = O)
- move_cell  in  4  target cell 0..8, row-major
- move_ready  out  1  block can accept a move this cycle
- move_ack  out  1  one-cycle pulse: move committed
- move_err  out  1  one-cycle pulse: move rejected
- marked  out  9  bit i = cell i occupied
- owner  out  9  bit i = player owning cell i; 0 where unmarked
- player  out  1  player of last committed move
- update  out  1  toggles once per committed move
- game_over  out  1  game finished; board frozen
- winner_valid  out  1  game_over due to a line win
- winner  out  1  winning player; valid only with winner_valid

Behaviour:
- Reset (rst=1) and clear have identical effect:
  - marked=0, owner=0, player=FIRST_PLAYER, update=0
  - move_ack=0, move_err=0, game_over=0, winner_valid=0, winner=0
  - state=PLAY
- rst has priority over clear; clear has priority over any move in the same cycle.
- Reset or clear mid-CHECK aborts the evaluation; no result is produced.
- FSM states: PLAY, CHECK, OVER.
- PLAY:
  - move_ready=1.
  - Handshake is move_valid & move_ready, sampled at the rising edge.
  - Reject when any of: move_cell>8; marked[move_cell]=1; ENFORCE_TURN=1 and move_player==player with marked!=0.
  - Reject -> move_err=1 next cycle, no state change, stay in PLAY.
  - Accept -> next edge sets:
    - marked[cell]=1 and owner[cell]=move_player
    - player=move_player
    - update toggled, move_ack=1
    - go to CHECK
- CHECK (exactly one cycle):
  - move_ready=0; move_valid is ignored with no ack and no err. The requester must hold or re-present the move.
  - The 8 lines (3 rows, 3 columns, 2 diagonals) are evaluated on the registered board.
  - A line wins when all 3 cells are marked and have equal owner.
  - Win -> game_over=1, winner_valid=1, winner=owner of the line; go to OVER.
  - Else, marked==9'h1FF -> game_over=1, winner_valid=0 (draw); go to OVER.
  - Else return to PLAY.
- OVER:
  - move_ready=0; all board outputs held.
  - Only rst or clear leave this state.
  - move_valid in OVER -> move_err=1 pulse.
- Latency:
  - Move accepted at edge N: marked/owner/player/update visible after N.
  - game_over visible after edge N+1.
  - Next move acceptable at edge N+2.
- marked and player change in the same edge as the update toggle, so the downstream checker sees consistent data on either edge of update.
- A draw on the 9th move with a simultaneous line completion reports the win (winner_valid=1).
- move_ack and move_err are never high together.

Decomposition:
- Shared package tictactoe_pkg:
  - player encoding constants PLAYER_X=0, PLAYER_O=1
  - NUM_CELLS=9
  - state enum {PLAY, CHECK, OVER}
  - the 8 win-line cell-index triples as a constant array
- One natural sub-module: line_win_detector. Combinational; inputs marked and owner; outputs win and win_player. Reusable by a future display/AI stage.

Test Plan:
- Reset, then X moves to cells 0, 1, 2 interleaved with O moves to cells 3, 4 -> after the 5th ack: marked=9'h01F, owner=9'h018, update has toggled 5 times (=1). Next cycle game_over=1, winner_valid=1, winner=0.
- Move to occupied cell 4, then to cell 9, then to cell 15 -> three move_err pulses. marked, owner and update unchanged; state stays PLAY.
- Full 9-move draw sequence X0 O1 X2 O4 X3 O5 X7 O6 X8 -> marked=9'h1FF, game_over=1, winner_valid=0. A 10th move gives move_err.
- ENFORCE_TURN=0, X plays twice (cells 0, 1) -> both acked, player=0 both times, update toggles twice. With ENFORCE_TURN=1, the second move gives move_err.
- move_valid held high continuously -> ack every other cycle, move_ready=0 during each CHECK cycle, no move lost or double-committed.
- clear asserted in the same cycle as a valid move, and in OVER -> move not committed; marked=0, player=FIRST_PLAYER, update=0, game_over=0, state PLAY.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe definitions: player encoding, board size, move FSM states
// and the eight winning cell triples (row-major cell numbering 0..8).
package tictactoe_pkg;

    localparam logic        PLAYER_X  = 1'b0;
    localparam logic        PLAYER_O  = 1'b1;
    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned NUM_LINES = 8;

    typedef enum logic [1:0] {
        PLAY,
        CHECK,
        OVER
    } state_t;

    // Rows, columns, then the two diagonals.
    localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

endpackage

// File: rtl/board_move_register_line_win_detector.sv
// Combinational three-in-a-row detector over the registered board; reports the
// first complete single-owner line found.
module line_win_detector
    import tictactoe_pkg::*;
(
    input  logic [8:0] marked,
    input  logic [8:0] owner,
    output logic       win,
    output logic       win_player
);

    always_comb begin
        win        = 1'b0;
        win_player = PLAYER_X;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            if (!win &&
                marked[WIN_LINES[i][0]] && marked[WIN_LINES[i][1]] && marked[WIN_LINES[i][2]] &&
                (owner[WIN_LINES[i][0]] == owner[WIN_LINES[i][1]]) &&
                (owner[WIN_LINES[i][1]] == owner[WIN_LINES[i][2]])) begin
                win        = 1'b1;
                win_player = owner[WIN_LINES[i][0]];
            end
        end
    end

endmodule

// File: rtl/board_move_register.sv
// Move acceptance and board storage feeding the players-error checker; judges
// win/draw one cycle after each commit and freezes the board when the game ends.
module board_move_register
    import tictactoe_pkg::*;
#(
    parameter logic FIRST_PLAYER = 1'b0,
    parameter bit   ENFORCE_TURN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       move_valid,
    input  logic       move_player,
    input  logic [3:0] move_cell,
    output logic       move_ready,
    output logic       move_ack,
    output logic       move_err,
    output logic [8:0] marked,
    output logic [8:0] owner,
    output logic       player,
    output logic       update,
    output logic       game_over,
    output logic       winner_valid,
    output logic       winner
);

    state_t      state;
    logic        line_win;
    logic        line_player;
    logic [15:0] marked_ext;
    logic [8:0]  cell_onehot;
    logic        cell_illegal;
    logic        cell_taken;
    logic        turn_violation;
    logic        reject;

    line_win_detector u_lines (
        .marked     (marked),
        .owner      (owner),
        .win        (line_win),
        .win_player (line_player)
    );

    // Zero-extended view keeps the occupancy lookup in range for cells 9..15.
    assign marked_ext     = {7'd0, marked};
    assign cell_onehot    = 9'd1 << move_cell;
    assign cell_illegal   = (move_cell > 4'd8);
    assign cell_taken     = marked_ext[move_cell];
    assign turn_violation = ENFORCE_TURN && (move_player == player) && (marked != '0);
    assign reject         = cell_illegal || cell_taken || turn_violation;

    assign move_ready = (state == PLAY);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state        <= PLAY;
            marked       <= '0;
            owner        <= '0;
            player       <= FIRST_PLAYER;
            update       <= 1'b0;
            move_ack     <= 1'b0;
            move_err     <= 1'b0;
            game_over    <= 1'b0;
            winner_valid <= 1'b0;
            winner       <= 1'b0;
        end else begin
            move_ack <= 1'b0;
            move_err <= 1'b0;
            case (state)
                PLAY: begin
                    if (move_valid) begin
                        if (reject) begin
                            move_err <= 1'b1;
                        end else begin
                            marked   <= marked | cell_onehot;
                            owner    <= move_player ? (owner | cell_onehot) : (owner & ~cell_onehot);
                            player   <= move_player;
                            update   <= ~update;
                            move_ack <= 1'b1;
                            state    <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    // A line completed on the ninth move outranks the draw.
                    if (line_win) begin
                        game_over    <= 1'b1;
                        winner_valid <= 1'b1;
                        winner       <= line_player;
                        state        <= OVER;
                    end else if (marked == 9'h1FF) begin
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        state <= PLAY;
                    end
                end
                OVER: begin
                    if (move_valid) begin
                        move_err <= 1'b1;
                    end
                end
                default: state <= PLAY;
            endcase
        end
    end

endmodule

// File: tb/tb_board_move_register.sv
// Scoreboard bench: move tasks queue the expected ack/err response and board
// snapshot; negedge monitors pop and compare whenever a DUT pulses ack or err.
module tb_board_move_register;

    typedef struct packed {
        logic       err;
        logic [8:0] marked;
        logic [8:0] owner;
        logic       player;
        logic       update;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    resp_t q1[$];
    resp_t q2[$];

    // DUT 1: defaults (FIRST_PLAYER=0, ENFORCE_TURN=0)
    logic       rst, clear, move_valid, move_player;
    logic [3:0] move_cell;
    logic       move_ready, move_ack, move_err, player, update;
    logic       game_over, winner_valid, winner;
    logic [8:0] marked, owner;

    // DUT 2: FIRST_PLAYER=1, ENFORCE_TURN=1
    logic       rst2, clear2, move_valid2, move_player2;
    logic [3:0] move_cell2;
    logic       move_ready2, move_ack2, move_err2, player2, update2;
    logic       game_over2, winner_valid2, winner2;
    logic [8:0] marked2, owner2;

    board_move_register #(.FIRST_PLAYER(1'b0), .ENFORCE_TURN(1'b0)) u_dut (
        .clk(clk), .rst(rst), .clear(clear),
        .move_valid(move_valid), .move_player(move_player), .move_cell(move_cell),
        .move_ready(move_ready), .move_ack(move_ack), .move_err(move_err),
        .marked(marked), .owner(owner), .player(player), .update(update),
        .game_over(game_over), .winner_valid(winner_valid), .winner(winner)
    );

    board_move_register #(.FIRST_PLAYER(1'b1), .ENFORCE_TURN(1'b1)) u_dut_turn (
        .clk(clk), .rst(rst2), .clear(clear2),
        .move_valid(move_valid2), .move_player(move_player2), .move_cell(move_cell2),
        .move_ready(move_ready2), .move_ack(move_ack2), .move_err(move_err2),
        .marked(marked2), .owner(owner2), .player(player2), .update(update2),
        .game_over(game_over2), .winner_valid(winner_valid2), .winner(winner2)
    );

    // Bench-side board model for DUT 1
    logic [8:0] m_marked, m_owner;
    logic       m_player, m_update;

    task automatic model_reset();
        m_marked = '0;
        m_owner  = '0;
        m_player = 1'b0;
        m_update = 1'b0;
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor_cmp(input string name, input logic ack, input logic err,
                               input resp_t act, inout resp_t q[$]);
        resp_t exp;
        if (ack && err) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_ack_err_both: got ack=1 err=1 expected one only", name);
        end else if (q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_unexpected: got ack=%0b err=%0b expected no response", name, ack, err);
        end else begin
            exp = q.pop_front();
            n_vec++;
            if (act !== exp) begin
                n_miss++;
                $display("FAIL %s_resp: got err=%0b marked=%h owner=%h player=%0b update=%0b expected err=%0b marked=%h owner=%h player=%0b update=%0b",
                         name, act.err, act.marked, act.owner, act.player, act.update,
                         exp.err, exp.marked, exp.owner, exp.player, exp.update);
            end
        end
    endtask

    always @(negedge clk) begin
        if (move_ack || move_err)
            monitor_cmp("dut", move_ack, move_err, '{move_err, marked, owner, player, update}, q1);
        if (move_ack2 || move_err2)
            monitor_cmp("dut_turn", move_ack2, move_err2, '{move_err2, marked2, owner2, player2, update2}, q2);
    end

    // Present one move for one cycle, then let the CHECK cycle pass.
    task automatic move(input logic p, input logic [3:0] c, input logic exp_err);
        if (!exp_err) begin
            m_marked[c] = 1'b1;
            m_owner[c]  = p;
            m_player    = p;
            m_update    = ~m_update;
        end
        q1.push_back('{exp_err, m_marked, m_owner, m_player, m_update});
        move_valid  = 1'b1;
        move_player = p;
        move_cell   = c;
        @(posedge clk); #1;
        move_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic move2(input logic p, input logic [3:0] c, input resp_t exp);
        q2.push_back(exp);
        move_valid2  = 1'b1;
        move_player2 = p;
        move_cell2   = c;
        @(posedge clk); #1;
        move_valid2 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
    endtask

    task automatic check_idle(input string name);
        check({name, "_marked"}, marked, 9'h000);
        check({name, "_owner"}, owner, 9'h000);
        check({name, "_player"}, {8'd0, player}, 9'd0);
        check({name, "_update"}, {8'd0, update}, 9'd0);
        check({name, "_game_over"}, {8'd0, game_over}, 9'd0);
        check({name, "_winner_valid"}, {8'd0, winner_valid}, 9'd0);
        check({name, "_ready"}, {8'd0, move_ready}, 9'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] hc [4];
        logic       hp [4];
        hc = '{4'd0, 4'd3, 4'd1, 4'd4};
        hp = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; clear = 1'b0; move_valid = 1'b0; move_player = 1'b0; move_cell = '0;
        rst2 = 1'b1; clear2 = 1'b0; move_valid2 = 1'b0; move_player2 = 1'b0; move_cell2 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rst2 = 1'b0;
        check_idle("reset");
        check("reset_ack_err", {7'd0, move_ack, move_err}, 9'd0);
        check("reset_winner", {8'd0, winner}, 9'd0);
        check("reset_player_first1", {8'd0, player2}, 9'd1);

        // X0 O3 X1 O4, three rejects, then X2 completes row 0
        move(1'b0, 4'd0, 1'b0);
        move(1'b1, 4'd3, 1'b0);
        move(1'b0, 4'd1, 1'b0);
        move(1'b1, 4'd4, 1'b0);
        move(1'b0, 4'd4, 1'b1);
        move(1'b0, 4'd9, 1'b1);
        move(1'b0, 4'd15, 1'b1);
        check("rej_ready", {8'd0, move_ready}, 9'd1);
        check("rej_marked", marked, 9'h01B);
        move(1'b0, 4'd2, 1'b0);
        check("win_marked", marked, 9'h01F);
        check("win_owner", owner, 9'h018);
        check("win_update", {8'd0, update}, 9'd1);
        check("win_game_over", {8'd0, game_over}, 9'd1);
        check("win_winner_valid", {8'd0, winner_valid}, 9'd1);
        check("win_winner", {8'd0, winner}, 9'd0);
        check("over_ready", {8'd0, move_ready}, 9'd0);
        move(1'b1, 4'd5, 1'b1);
        check("over_frozen_marked", marked, 9'h01F);

        do_clear();
        check_idle("clear_over");

        // Full-board draw
        move(1'b0, 4'd0, 1'b0); move(1'b1, 4'd1, 1'b0); move(1'b0, 4'd2, 1'b0);
        move(1'b1, 4'd4, 1'b0); move(1'b0, 4'd3, 1'b0); move(1'b1, 4'd5, 1'b0);
        move(1'b0, 4'd7, 1'b0); move(1'b1, 4'd6, 1'b0);
        check("draw_not_over_8", {8'd0, game_over}, 9'd0);
        move(1'b0, 4'd8, 1'b0);
        check("draw_marked", marked, 9'h1FF);
        check("draw_owner", owner, 9'h072);
        check("draw_game_over", {8'd0, game_over}, 9'd1);
        check("draw_winner_valid", {8'd0, winner_valid}, 9'd0);
        move(1'b1, 4'd0, 1'b1);

        // Clear in the same cycle as a legal move: move must not commit
        clear = 1'b1; move_valid = 1'b1; move_player = 1'b1; move_cell = 4'd4;
        @(posedge clk); #1;
        clear = 1'b0; move_valid = 1'b0;
        model_reset();
        check_idle("clear_with_move");

        // Same player twice is committed when turn order is not enforced
        move(1'b0, 4'd0, 1'b0);
        check("twice_player_a", {8'd0, player}, 9'd0);
        move(1'b0, 4'd1, 1'b0);
        check("twice_player_b", {8'd0, player}, 9'd0);
        check("twice_update", {8'd0, update}, 9'd0);
        do_clear();

        // move_valid held high: ack every other cycle, CHECK ignores the request
        move_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            move_player = hp[k];
            move_cell   = hc[k];
            m_marked[hc[k]] = 1'b1;
            m_owner[hc[k]]  = hp[k];
            m_player        = hp[k];
            m_update        = ~m_update;
            q1.push_back('{1'b0, m_marked, m_owner, m_player, m_update});
            @(posedge clk); #1;
            check("hold_ready_check", {8'd0, move_ready}, 9'd0);
            @(posedge clk); #1;
            check("hold_ready_play", {8'd0, move_ready}, 9'd1);
        end
        move_valid = 1'b0;
        check("hold_marked", marked, 9'h01B);
        check("hold_owner", owner, 9'h018);
        do_clear();

        // Ninth move fills the board and completes the 0-4-8 diagonal
        move(1'b0, 4'd0, 1'b0); move(1'b1, 4'd2, 1'b0); move(1'b0, 4'd1, 1'b0);
        move(1'b1, 4'd3, 1'b0); move(1'b0, 4'd5, 1'b0); move(1'b1, 4'd6, 1'b0);
        move(1'b0, 4'd8, 1'b0); move(1'b1, 4'd7, 1'b0); move(1'b0, 4'd4, 1'b0);
        check("full_win_marked", marked, 9'h1FF);
        check("full_win_owner", owner, 9'h0CC);
        check("full_win_game_over", {8'd0, game_over}, 9'd1);
        check("full_win_winner_valid", {8'd0, winner_valid}, 9'd1);
        check("full_win_winner", {8'd0, winner}, 9'd0);

        // Turn enforcement
        move2(1'b0, 4'd0, '{1'b0, 9'h001, 9'h000, 1'b0, 1'b1});
        move2(1'b0, 4'd1, '{1'b1, 9'h001, 9'h000, 1'b0, 1'b1});
        move2(1'b1, 4'd1, '{1'b0, 9'h003, 9'h002, 1'b1, 1'b0});
        check("turn_marked", marked2, 9'h003);

        repeat (3) @(posedge clk);
        #1;
        check("queue_dut_empty", q1.size(), 9'd0);
        check("queue_turn_empty", q2.size(), 9'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
